// File: rtl/uv_apb_to_bus.sv
// APB completer that turns each APB transfer into a single req/rsp bus transaction.
// One transaction in flight; the APB access phase is stretched until the bus response returns.
module uv_apb_to_bus #(
    parameter int unsigned ALEN = 12,
    parameter int unsigned DLEN = 32,
    parameter int unsigned MLEN = DLEN / 8
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            apb_psel,
    input  logic            apb_penable,
    input  logic [2:0]      apb_pprot,
    input  logic [ALEN-1:0] apb_paddr,
    input  logic [MLEN-1:0] apb_pstrb,
    input  logic            apb_pwrite,
    input  logic [DLEN-1:0] apb_pwdata,
    output logic [DLEN-1:0] apb_prdata,
    output logic            apb_pready,
    output logic            apb_pslverr,

    output logic            bus_req_vld,
    input  logic            bus_req_rdy,
    output logic            bus_req_read,
    output logic [ALEN-1:0] bus_req_addr,
    output logic [MLEN-1:0] bus_req_mask,
    output logic [DLEN-1:0] bus_req_data,

    input  logic            bus_rsp_vld,
    output logic            bus_rsp_rdy,
    input  logic [1:0]      bus_rsp_excp,
    input  logic [DLEN-1:0] bus_rsp_data
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP,
        DONE
    } state_t;

    state_t            state_q, state_d;

    logic [DLEN-1:0]   prdata_d;
    logic              pready_d;
    logic              pslverr_d;
    logic              req_vld_d;
    logic              req_read_d;
    logic [ALEN-1:0]   req_addr_d;
    logic [MLEN-1:0]   req_mask_d;
    logic [DLEN-1:0]   req_data_d;
    logic              rsp_rdy_d;

    // Protection attributes have no equivalent on the native bus.
    logic              unused_pprot;
    assign unused_pprot = ^apb_pprot;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        prdata_d   = apb_prdata;
        pready_d   = apb_pready;
        pslverr_d  = apb_pslverr;
        req_vld_d  = bus_req_vld;
        req_read_d = bus_req_read;
        req_addr_d = bus_req_addr;
        req_mask_d = bus_req_mask;
        req_data_d = bus_req_data;
        rsp_rdy_d  = bus_rsp_rdy;

        case (state_q)
            IDLE: begin
                // Only a genuine setup phase starts a transfer; psel+penable alone is ignored.
                if (apb_psel && !apb_penable) begin
                    req_vld_d  = 1'b1;
                    req_read_d = !apb_pwrite;
                    req_addr_d = apb_paddr;
                    req_data_d = apb_pwdata;
                    req_mask_d = apb_pwrite ? apb_pstrb : {MLEN{1'b1}};
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (bus_req_rdy) begin
                    req_vld_d = 1'b0;
                    rsp_rdy_d = 1'b1;
                    state_d   = RSP;
                end
            end
            RSP: begin
                if (bus_rsp_vld) begin
                    if (bus_req_read) begin
                        prdata_d = bus_rsp_data;
                    end
                    pslverr_d = |bus_rsp_excp;
                    pready_d  = 1'b1;
                    rsp_rdy_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            apb_prdata   <= '0;
            apb_pready   <= 1'b0;
            apb_pslverr  <= 1'b0;
            bus_req_vld  <= 1'b0;
            bus_req_read <= 1'b0;
            bus_req_addr <= '0;
            bus_req_mask <= '0;
            bus_req_data <= '0;
            bus_rsp_rdy  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from the pre-edge values together.
            state_q      <= state_d;
            apb_prdata   <= prdata_d;
            apb_pready   <= pready_d;
            apb_pslverr  <= pslverr_d;
            bus_req_vld  <= req_vld_d;
            bus_req_read <= req_read_d;
            bus_req_addr <= req_addr_d;
            bus_req_mask <= req_mask_d;
            bus_req_data <= req_data_d;
            bus_rsp_rdy  <= rsp_rdy_d;
        end
    end

endmodule

// File: tb/tb_uv_apb_to_bus.sv
// Self-checking bench for uv_apb_to_bus: directed scenarios plus randomized transfers
// compared cycle by cycle against a timeline model derived from the transfer parameters.
module tb_uv_apb_to_bus;

    localparam int ALEN = 12;
    localparam int DLEN = 32;
    localparam int MLEN = DLEN / 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            apb_psel;
    logic            apb_penable;
    logic [2:0]      apb_pprot;
    logic [ALEN-1:0] apb_paddr;
    logic [MLEN-1:0] apb_pstrb;
    logic            apb_pwrite;
    logic [DLEN-1:0] apb_pwdata;
    logic [DLEN-1:0] apb_prdata;
    logic            apb_pready;
    logic            apb_pslverr;
    logic            bus_req_vld;
    logic            bus_req_rdy;
    logic            bus_req_read;
    logic [ALEN-1:0] bus_req_addr;
    logic [MLEN-1:0] bus_req_mask;
    logic [DLEN-1:0] bus_req_data;
    logic            bus_rsp_vld;
    logic            bus_rsp_rdy;
    logic [1:0]      bus_rsp_excp;
    logic [DLEN-1:0] bus_rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the only state visible across transfers: last read data returned.
    logic [DLEN-1:0] exp_prdata;

    uv_apb_to_bus #(.ALEN(ALEN), .DLEN(DLEN), .MLEN(MLEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .apb_psel     (apb_psel),
        .apb_penable  (apb_penable),
        .apb_pprot    (apb_pprot),
        .apb_paddr    (apb_paddr),
        .apb_pstrb    (apb_pstrb),
        .apb_pwrite   (apb_pwrite),
        .apb_pwdata   (apb_pwdata),
        .apb_prdata   (apb_prdata),
        .apb_pready   (apb_pready),
        .apb_pslverr  (apb_pslverr),
        .bus_req_vld  (bus_req_vld),
        .bus_req_rdy  (bus_req_rdy),
        .bus_req_read (bus_req_read),
        .bus_req_addr (bus_req_addr),
        .bus_req_mask (bus_req_mask),
        .bus_req_data (bus_req_data),
        .bus_rsp_vld  (bus_rsp_vld),
        .bus_rsp_rdy  (bus_rsp_rdy),
        .bus_rsp_excp (bus_rsp_excp),
        .bus_rsp_data (bus_rsp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".vld"},     32'(bus_req_vld), 32'd0);
        check({tag, ".rsp_rdy"}, 32'(bus_rsp_rdy), 32'd0);
        check({tag, ".pready"},  32'(apb_pready),  32'd0);
        check({tag, ".pslverr"}, 32'(apb_pslverr), 32'd0);
        check({tag, ".prdata"},  apb_prdata,       exp_prdata);
    endtask

    task automatic check_reset_values(input string tag);
        exp_prdata = '0;
        check_idle(tag);
        check({tag, ".read"}, 32'(bus_req_read), 32'd0);
        check({tag, ".addr"}, 32'(bus_req_addr), 32'd0);
        check({tag, ".mask"}, 32'(bus_req_mask), 32'd0);
        check({tag, ".data"}, bus_req_data,      32'd0);
    endtask

    // Idle cycles; with abuse set the master drives psel+penable with no setup phase.
    task automatic idle(input int n, input bit abuse);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_idle("idle");
            apb_psel     = abuse;
            apb_penable  = abuse;
            apb_pwrite   = 1'($urandom);
            apb_paddr    = ALEN'($urandom);
            bus_req_rdy  = 1'($urandom);
            bus_rsp_vld  = 1'($urandom);
            bus_rsp_data = $urandom;
            bus_rsp_excp = 2'($urandom);
        end
    endtask

    // One APB transfer. Bus side: request accepted after rdy_d stalled cycles, response
    // after rsp_d further cycles. Timeline (i = negedge index after the setup edge):
    // vld on 1..rdy_d+1, rsp_rdy on rdy_d+2..rdy_d+rsp_d+2, pready only on rdy_d+rsp_d+3.
    task automatic xfer(input bit wr, input logic [ALEN-1:0] addr, input logic [MLEN-1:0] strb,
                        input logic [DLEN-1:0] wdata, input int rdy_d, input int rsp_d,
                        input logic [1:0] excp, input logic [DLEN-1:0] rdata,
                        input bit drop_psel, input int abort_at);
        int              p       = rdy_d + rsp_d + 3;
        int              rsp_at  = rdy_d + rsp_d + 2;
        logic [MLEN-1:0] exp_msk = wr ? strb : {MLEN{1'b1}};
        @(negedge clk);
        check_idle("pre");
        apb_psel     = 1'b1;
        apb_penable  = 1'b0;
        apb_pwrite   = wr;
        apb_paddr    = addr;
        apb_pstrb    = strb;
        apb_pwdata   = wdata;
        apb_pprot    = 3'($urandom);
        bus_req_rdy  = 1'($urandom);
        bus_rsp_vld  = 1'($urandom);
        bus_rsp_data = $urandom;
        bus_rsp_excp = 2'($urandom);
        for (int i = 1; i <= p; i++) begin
            @(negedge clk);
            if (i == abort_at) begin
                rst_n       = 1'b0;
                apb_psel    = 1'b0;
                apb_penable = 1'b0;
                bus_rsp_vld = 1'b0;
                @(negedge clk);
                check_reset_values("abort");
                rst_n = 1'b1;
                return;
            end
            if (i == p && !wr) exp_prdata = rdata;
            check("vld",     32'(bus_req_vld), 32'(i <= rdy_d + 1));
            check("rsp_rdy", 32'(bus_rsp_rdy), 32'(i >= rdy_d + 2 && i <= rsp_at));
            check("pready",  32'(apb_pready),  32'(i == p));
            check("pslverr", 32'(apb_pslverr), 32'(i == p && excp != 2'b00));
            check("prdata",  apb_prdata,       exp_prdata);
            if (i <= rdy_d + 1) begin
                check("req_read", 32'(bus_req_read), 32'(!wr));
                check("req_addr", 32'(bus_req_addr), 32'(addr));
                check("req_mask", 32'(bus_req_mask), 32'(exp_msk));
                if (wr) check("req_data", bus_req_data, wdata);
            end
            apb_penable = 1'b1;
            if (drop_psel && i >= 2) begin
                apb_psel    = 1'b0;
                apb_penable = 1'b0;
            end
            bus_req_rdy = (i >= rdy_d + 1);
            if (i == rsp_at) begin
                bus_rsp_vld  = 1'b1;
                bus_rsp_excp = excp;
                bus_rsp_data = rdata;
            end else if (i <= rdy_d + 1) begin
                // Responses offered before RSP must be ignored.
                bus_rsp_vld  = 1'($urandom);
                bus_rsp_excp = 2'($urandom);
                bus_rsp_data = $urandom;
            end else begin
                bus_rsp_vld = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        apb_psel     = 1'b0;
        apb_penable  = 1'b0;
        apb_pprot    = '0;
        apb_paddr    = '0;
        apb_pstrb    = '0;
        apb_pwrite   = 1'b0;
        apb_pwdata   = '0;
        bus_req_rdy  = 1'b0;
        bus_rsp_vld  = 1'b0;
        bus_rsp_excp = '0;
        bus_rsp_data = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Write with immediate ready: pready on the third negedge after setup edge.
        xfer(1'b1, 12'h010, 4'hF, 32'hDEADBEEF, 0, 0, 2'b00, 32'h0, 1'b0, 0);
        // Read with 4 cycles of backpressure and response after 2 RSP cycles.
        xfer(1'b0, 12'h024, 4'h0, 32'h0, 4, 2, 2'b00, 32'h12345678, 1'b0, 0);
        // Error response on a read.
        xfer(1'b0, 12'h030, 4'h0, 32'h0, 1, 0, 2'b10, 32'hCAFEF00D, 1'b0, 0);
        // Partial write followed by a back-to-back transfer.
        xfer(1'b1, 12'h040, 4'h6, 32'hA5A5A5A5, 0, 1, 2'b00, 32'h0, 1'b0, 0);
        xfer(1'b0, 12'h044, 4'h3, 32'h0, 0, 0, 2'b01, 32'h0BADC0DE, 1'b0, 0);
        // Reset while in RSP, then a normal write.
        xfer(1'b0, 12'h050, 4'h0, 32'h0, 0, 3, 2'b00, 32'h11111111, 1'b0, 3);
        xfer(1'b1, 12'h004, 4'hF, 32'h55AA55AA, 0, 0, 2'b00, 32'h0, 1'b0, 0);
        // Access phase without setup, then psel dropped during REQ.
        idle(3, 1'b1);
        idle(1, 1'b0);
        xfer(1'b1, 12'h0F0, 4'h9, 32'h01020304, 3, 1, 2'b00, 32'h0, 1'b1, 0);
        idle(2, 1'b0);

        for (int t = 0; t < 150; t++) begin
            xfer(1'($urandom), ALEN'($urandom), MLEN'($urandom), $urandom,
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                 ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                 $urandom, ($urandom_range(0, 7) == 0), 0);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
